// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and constants for the MIPS memory access stage
//
// Contents:
//   state_t         access FSM encoding (IDLE, BUSY, DONE)
//   target_t        destination of read data (none, IR, MDR)
//   OP_MSB/OP_LSB   opcode field position inside the instruction word
//   TIMEOUT_DEFAULT default abort limit in BUSY cycles
//   CTR_WIDTH       width of the timeout counter
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE = 2'b00,
        TGT_IR   = 2'b01,
        TGT_MDR  = 2'b10
    } target_t;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int          CTR_WIDTH       = 8;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - BUSY-cycle counter that flags an access timeout
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset, count -> 0
//   clear    in   restart the count at 0 (new access issued)
//   enable   in   count one BUSY cycle
//   expired  out  this BUSY cycle brings the count to TIMEOUT
module mem_timeout_ctr
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CTR_WIDTH-1:0] LIMIT = CTR_WIDTH'(TIMEOUT);

    logic [CTR_WIDTH-1:0] count;
    logic [CTR_WIDTH-1:0] count_inc;

    assign count_inc = count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_inc;
        end
    end

    // The count holds the number of BUSY cycles already completed, so the
    // increment taken in the current cycle is the one that reaches TIMEOUT.
    // This makes the access abort after exactly TIMEOUT BUSY cycles.
    assign expired = enable && (count_inc == LIMIT);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multicycle MIPS memory stage: req/ack memory port, IR and MDR
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   i_or_d                  address select: 0 = pc, 1 = alu_out
//   ir_write                fetch request, read data loads IR
//   mem_read                load request, read data loads MDR
//   mem_write               store request
//   pc, alu_out, write_data fetch address, data address, store data
//   mem_req, mem_we         registered memory request and write enable
//   mem_addr, mem_wdata     registered address and store data
//   mem_rdata, mem_ack      read data and single-cycle completion pulse
//   instr, op               IR contents and its opcode field
//   mem_data                MDR contents
//   stall                   hold the control FSM while an access is pending
//   timeout_err             sticky flag, an access was aborted with no ack
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_or_d,
    input  logic                  ir_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [5:0]            op,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  stall,
    output logic                  timeout_err
);

    state_t  state_q;
    state_t  state_d;
    target_t target_q;
    logic    req;
    logic    expired;
    logic    start;

    assign req   = ir_write | mem_read | mem_write;
    assign start = (state_q == IDLE) && req;
    assign stall = start || (state_q == BUSY);
    assign op    = instr[OP_MSB:OP_LSB];

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .enable  (state_q == BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE always returns to IDLE: the controller advances on the DONE edge,
    // so a request still visible there belongs to the old access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = BUSY;
            BUSY:    if (mem_ack || expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr       <= '0;
            mem_data    <= '0;
            timeout_err <= 1'b0;
            target_q    <= TGT_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write;
                        mem_addr  <= i_or_d ? alu_out : pc;
                        mem_wdata <= write_data;
                        // A store suppresses any read request raised with it.
                        if (mem_write) begin
                            target_q <= TGT_NONE;
                        end else if (ir_write) begin
                            target_q <= TGT_IR;
                        end else begin
                            target_q <= TGT_MDR;
                        end
                    end
                end
                BUSY: begin
                    // ack is tested first so a coincident timeout is ignored
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (target_q == TGT_IR) begin
                            instr <= mem_rdata;
                        end else if (target_q == TGT_MDR) begin
                            mem_data <= mem_rdata;
                        end
                    end else if (expired) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_or_d = 1'b0;
    logic        ir_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] write_data = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic        req_a, we_a, stall_a, terr_a;
    logic [31:0] addr_a, wdata_a, instr_a, mdata_a;
    logic [5:0]  op_a;
    logic        req_b, we_b, stall_b, terr_b;
    logic [31:0] addr_b, wdata_b, instr_b, mdata_b;
    logic [5:0]  op_b;

    always #5 clk = ~clk;

    mem_access_unit dut_a (
        .clk(clk), .reset(reset), .i_or_d(i_or_d), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .pc(pc), .alu_out(alu_out),
        .write_data(write_data), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr(instr_a), .op(op_a), .mem_data(mdata_a), .stall(stall_a),
        .timeout_err(terr_a)
    );

    mem_access_unit #(.TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .i_or_d(i_or_d), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .pc(pc), .alu_out(alu_out),
        .write_data(write_data), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr(instr_b), .op(op_b), .mem_data(mdata_b), .stall(stall_b),
        .timeout_err(terr_b)
    );

    bit          use_b = 1'b0;
    logic        c_stall, c_req, c_we, c_terr;
    logic [31:0] c_addr, c_wdata, c_instr, c_mdata;
    logic [5:0]  c_op;

    always_comb begin
        c_stall = use_b ? stall_b : stall_a;
        c_req   = use_b ? req_b   : req_a;
        c_we    = use_b ? we_b    : we_a;
        c_terr  = use_b ? terr_b  : terr_a;
        c_addr  = use_b ? addr_b  : addr_a;
        c_wdata = use_b ? wdata_b : wdata_a;
        c_instr = use_b ? instr_b : instr_a;
        c_mdata = use_b ? mdata_b : mdata_a;
        c_op    = use_b ? op_b    : op_a;
    end

    typedef struct {
        logic        irw, mrd, mwr, iod;
        logic [31:0] pc, alu, wdata;
        int          ack_at;
        logic [31:0] rdata;
        bit          use_b;
        logic [31:0] exp_addr;
        logic        exp_we;
        int          exp_stalls;
        logic [31:0] exp_instr, exp_mdata;
        logic        exp_terr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic irw, mrd, mwr, iod,
                                input logic [31:0] p, a, wd, input int ack_at,
                                input logic [31:0] rd, input bit b,
                                input logic [31:0] eaddr, input logic ewe,
                                input int est, input logic [31:0] ei, em,
                                input logic et);
        vec_t v;
        v.irw = irw; v.mrd = mrd; v.mwr = mwr; v.iod = iod;
        v.pc = p; v.alu = a; v.wdata = wd; v.ack_at = ack_at; v.rdata = rd;
        v.use_b = b; v.exp_addr = eaddr; v.exp_we = ewe; v.exp_stalls = est;
        v.exp_instr = ei; v.exp_mdata = em; v.exp_terr = et;
        return v;
    endfunction

    // Starts in IDLE just after a falling edge; ends one cycle after DONE.
    task automatic run_vec(input int idx, input vec_t v);
        int  stalls = 0;
        int  busy = 0;
        bit  stable = 1'b1;
        bit  done_seen = 1'b0;
        string tag;
        tag = $sformatf("v%0d", idx);
        use_b = v.use_b;
        ir_write = v.irw; mem_read = v.mrd; mem_write = v.mwr; i_or_d = v.iod;
        pc = v.pc; alu_out = v.alu; write_data = v.wdata;
        #1;
        for (int g = 0; g < 300; g++) begin
            if (!c_stall) begin
                done_seen = 1'b1;
                break;
            end
            stalls++;
            if (stalls > 1) begin
                busy++;
                if (c_req !== 1'b1 || c_addr !== v.exp_addr || c_we !== v.exp_we ||
                    c_wdata !== v.wdata) stable = 1'b0;
                if (busy == v.ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = '0;
        end
        chk({tag, "_done_reached"}, 32'(done_seen), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(v.exp_stalls));
        chk({tag, "_busy_outputs_stable"}, 32'(stable), 32'd1);
        ir_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk({tag, "_req_dropped"}, 32'(c_req), 32'd0);
        chk({tag, "_we_dropped"}, 32'(c_we), 32'd0);
        chk({tag, "_addr"}, c_addr, v.exp_addr);
        chk({tag, "_wdata"}, c_wdata, v.wdata);
        chk({tag, "_instr"}, c_instr, v.exp_instr);
        chk({tag, "_op"}, 32'(c_op), 32'(v.exp_instr[31:26]));
        chk({tag, "_mem_data"}, c_mdata, v.exp_mdata);
        chk({tag, "_timeout_err"}, 32'(c_terr), 32'(v.exp_terr));
        @(negedge clk);
        chk({tag, "_idle_no_stall"}, 32'(c_stall), 32'd0);
    endtask

    vec_t tbl[7];
    vec_t tmo;

    initial begin
        //            irw  mrd  mwr  iod  pc            alu           wdata         ack rdata         b     addr          we  st instr         mdata         terr
        tbl[0] = mk(1'b1,1'b0,1'b0,1'b0,32'h00000040,32'h0,       32'h0,        3,32'h8C220004,1'b0,32'h00000040,1'b0,4,32'h8C220004,32'h0,       1'b0);
        tbl[1] = mk(1'b0,1'b1,1'b0,1'b1,32'h0,       32'h00000100,32'h0,        1,32'hDEADBEEF,1'b0,32'h00000100,1'b0,2,32'h8C220004,32'hDEADBEEF,1'b0);
        tbl[2] = mk(1'b0,1'b0,1'b1,1'b1,32'h0,       32'h00000104,32'h12345678, 2,32'hFFFFFFFF,1'b0,32'h00000104,1'b1,3,32'h8C220004,32'hDEADBEEF,1'b0);
        tbl[3] = mk(1'b1,1'b1,1'b1,1'b0,32'h00000200,32'h00000300,32'hA5A5A5A5, 1,32'h11111111,1'b0,32'h00000200,1'b1,2,32'h8C220004,32'hDEADBEEF,1'b0);
        tbl[4] = mk(1'b1,1'b1,1'b0,1'b0,32'h00000044,32'h00000500,32'h0,        2,32'h00421820,1'b0,32'h00000044,1'b0,3,32'h00421820,32'hDEADBEEF,1'b0);
        tbl[5] = mk(1'b1,1'b0,1'b0,1'b1,32'h00000048,32'h00000300,32'h0,        1,32'hAC030008,1'b0,32'h00000300,1'b0,2,32'hAC030008,32'hDEADBEEF,1'b0);
        tbl[6] = mk(1'b1,1'b0,1'b0,1'b0,32'h0000004C,32'h0,       32'h0,        4,32'h20010005,1'b1,32'h0000004C,1'b0,5,32'h20010005,32'hDEADBEEF,1'b0);
        tmo    = mk(1'b1,1'b0,1'b0,1'b0,32'h00000090,32'h0,       32'h0,        0,32'h0,       1'b1,32'h00000090,1'b0,5,32'h0,       32'h0,       1'b1);

        // reset state
        #3;
        chk("rst_mem_req", 32'(req_a), 32'd0);
        chk("rst_mem_we", 32'(we_a), 32'd0);
        chk("rst_mem_addr", addr_a, 32'h0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_mem_data", mdata_a, 32'h0);
        chk("rst_stall", 32'(stall_a), 32'd0);
        chk("rst_timeout_err", 32'(terr_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, tbl[i]);
        end
        use_b = 1'b0;

        // stray ack in IDLE
        mem_ack = 1'b1;
        mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
        #1;
        chk("idle_ack_instr", instr_a, 32'h20010005);
        chk("idle_ack_mem_data", mdata_a, 32'hDEADBEEF);
        chk("idle_ack_req", 32'(req_a), 32'd0);
        chk("idle_ack_stall", 32'(stall_a), 32'd0);
        @(negedge clk);

        // async reset in the middle of BUSY, between clock edges
        ir_write = 1'b1;
        pc = 32'h00000080;
        @(negedge clk);
        chk("mid_busy_req", 32'(req_a), 32'd1);
        ir_write = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(req_a), 32'd0);
        chk("async_rst_stall", 32'(stall_a), 32'd0);
        chk("async_rst_instr", instr_a, 32'h0);
        chk("async_rst_mem_data", mdata_a, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h13572468;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
        #1;
        chk("late_ack_instr", instr_a, 32'h0);
        chk("late_ack_req", 32'(req_a), 32'd0);
        chk("late_ack_stall", 32'(stall_a), 32'd0);
        @(negedge clk);

        // abort with no ack on the TIMEOUT=4 instance
        run_vec(7, tmo);
        repeat (3) @(negedge clk);
        chk("timeout_err_sticky", 32'(terr_b), 32'd1);
        chk("timeout_instr_kept", instr_b, 32'h0);
        chk("timeout_req_low", 32'(req_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
